// File: rtl/slv_i2c_line_cond_pkg.sv
// slv_i2c_line_cond_pkg: default timing constants and helpers for the I2C slave line conditioner
package slv_i2c_line_cond_pkg;
  localparam int SYNC_STG_DEF = 2;
  localparam int FLT_LEN_DEF  = 4;
  localparam int CNT_W_DEF    = 12;
  localparam int MDL_DEF_DEF  = 125;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/slv_i2c_line_flt.sv
// slv_i2c_line_flt: synchroniser, glitch filter and edge strobes for one open-drain line
module slv_i2c_line_flt
  import slv_i2c_line_cond_pkg::*;
#(
  parameter int SYNC_STG = SYNC_STG_DEF,
  parameter int FLT_LEN  = FLT_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_lvl,
  output logic o_rs,
  output logic o_fl
);
  localparam int FW = cnt_w(FLT_LEN);
  logic [SYNC_STG-1:0] sync_q, sync_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic flt_q, flt_d, dly_q, dly_d;
  logic synced, hit;
  // shift the pad into the synchroniser; follow the synced level once it held for FLT_LEN cycles
  always_comb begin
    sync_d = {sync_q[SYNC_STG-2:0], i_raw};
    synced = sync_q[SYNC_STG-1];
    hit    = (synced != flt_q) && (cnt_q == FW'(FLT_LEN - 1));
    cnt_d  = (synced == flt_q || hit) ? '0 : cnt_q + FW'(1);
    flt_d  = hit ? synced : flt_q;
    dly_d  = flt_q;
  end
  // state registers; idle-high bus after reset so no edge is seen on release
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      cnt_q  <= '0;
      flt_q  <= 1'b1;
      dly_q  <= 1'b1;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      flt_q  <= flt_d;
      dly_q  <= dly_d;
    end
  end
  assign o_lvl = flt_q;
  assign o_rs  = flt_q & ~dly_q;
  assign o_fl  = ~flt_q & dly_q;
endmodule

// File: rtl/slv_i2c_line_cond.sv
// slv_i2c_line_cond: conditions raw SCL/SDA into clean levels, edge, START/STOP and mid-phase strobes
module slv_i2c_line_cond
  import slv_i2c_line_cond_pkg::*;
#(
  parameter int SYNC_STG = SYNC_STG_DEF,
  parameter int FLT_LEN  = FLT_LEN_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MDL_DEF  = MDL_DEF_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic I_IO_SCL,
  input  logic I_IO_SDA,
  output logic O_SCL,
  output logic O_SDA_IN,
  output logic O_RS_IO_SCL,
  output logic O_FL_IO_SCL,
  output logic O_RS_IO_SDA,
  output logic O_FL_IO_SDA,
  output logic O_START,
  output logic O_STOP,
  output logic O_MDL_LW_IO_SCL,
  output logic O_MDL_HG_IO_SCL
);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CDEF = CNT_W'(MDL_DEF);
  logic [CNT_W-1:0] lw_cnt_q, lw_cnt_d, hg_cnt_q, hg_cnt_d;
  logic [CNT_W-1:0] lw_half_q, lw_half_d, hg_half_q, hg_half_d;
  slv_i2c_line_flt #(.SYNC_STG(SYNC_STG), .FLT_LEN(FLT_LEN)) u_scl (
    .clk(CLK), .rst(RST), .i_raw(I_IO_SCL),
    .o_lvl(O_SCL), .o_rs(O_RS_IO_SCL), .o_fl(O_FL_IO_SCL)
  );
  slv_i2c_line_flt #(.SYNC_STG(SYNC_STG), .FLT_LEN(FLT_LEN)) u_sda (
    .clk(CLK), .rst(RST), .i_raw(I_IO_SDA),
    .o_lvl(O_SDA_IN), .o_rs(O_RS_IO_SDA), .o_fl(O_FL_IO_SDA)
  );
  // SCL high now and not just risen means it was high last cycle too
  assign O_START = O_SCL & ~O_RS_IO_SCL & O_FL_IO_SDA;
  assign O_STOP  = O_SCL & ~O_RS_IO_SCL & O_RS_IO_SDA;
  // phase timers: a zero count means the phase kind has not started since reset, so it neither runs nor updates its half
  always_comb begin
    lw_cnt_d  = O_FL_IO_SCL ? CNT_W'(1) :
                (!O_SCL && lw_cnt_q != '0 && lw_cnt_q != CMAX) ? lw_cnt_q + CNT_W'(1) : lw_cnt_q;
    hg_cnt_d  = O_RS_IO_SCL ? CNT_W'(1) :
                (O_SCL && hg_cnt_q != '0 && hg_cnt_q != CMAX) ? hg_cnt_q + CNT_W'(1) : hg_cnt_q;
    lw_half_d = !(O_RS_IO_SCL && lw_cnt_q != '0) ? lw_half_q :
                (lw_cnt_q[CNT_W-1:1] == '0) ? CNT_W'(1) : {1'b0, lw_cnt_q[CNT_W-1:1]};
    hg_half_d = !(O_FL_IO_SCL && hg_cnt_q != '0) ? hg_half_q :
                (hg_cnt_q[CNT_W-1:1] == '0) ? CNT_W'(1) : {1'b0, hg_cnt_q[CNT_W-1:1]};
  end
  // timer registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      lw_cnt_q  <= '0;
      hg_cnt_q  <= '0;
      lw_half_q <= CDEF;
      hg_half_q <= CDEF;
    end else begin
      lw_cnt_q  <= lw_cnt_d;
      hg_cnt_q  <= hg_cnt_d;
      lw_half_q <= lw_half_d;
      hg_half_q <= hg_half_d;
    end
  end
  // the edge cycle still holds the previous phase count, so it is excluded from the match
  assign O_MDL_LW_IO_SCL = ~O_SCL & ~O_FL_IO_SCL & (lw_cnt_q == lw_half_q);
  assign O_MDL_HG_IO_SCL = O_SCL & ~O_RS_IO_SCL & (hg_cnt_q == hg_half_q);
endmodule
